// File: rtl/tetris_engine.sv
// Piece lifecycle controller for a COLS x ROWS board: spawn, moves, gravity, hard drop, lock, row clear, game over.
// Define TETRIS_SCORE_EN to enable the score accumulator; otherwise score is tied to zero.
module tetris_engine #(
    parameter int unsigned COLS          = 10,
    parameter int unsigned ROWS          = 20,
    parameter int unsigned CELL_W        = 3,
    parameter int unsigned ID_W          = 8,
    parameter int unsigned GRAVITY_TICKS = 32,
    parameter int unsigned SPAWN_X       = 4,
    parameter int unsigned SPAWN_Y       = ROWS - 2
) (
    input  logic                          main_clk,
    input  logic                          rst_1plus,
    input  logic                          mv_left,
    input  logic                          mv_right,
    input  logic                          mv_down,
    input  logic                          rot,
    input  logic                          drop,
    input  logic [CELL_W-1:0]             next_type,
    input  logic                          is_collided,
    input  logic [4*ID_W-1:0]             cur_ids,
    output logic [ID_W-1:0]               try_x,
    output logic [ID_W-1:0]               try_y,
    output logic [1:0]                    try_dir,
    output logic [CELL_W-1:0]             try_type,
    output logic [ID_W-1:0]               cur_x,
    output logic [ID_W-1:0]               cur_y,
    output logic [1:0]                    cur_dir,
    output logic [CELL_W-1:0]             cur_type,
    output logic [COLS*ROWS*CELL_W-1:0]   board,
    output logic [2:0]                    state,
    output logic [15:0]                   lines,
    output logic [19:0]                   score,
    output logic                          game_over
);

    localparam int unsigned CELLS   = COLS * ROWS;
    localparam int unsigned ROW_W   = COLS * CELL_W;
    localparam int unsigned BOARD_W = CELLS * CELL_W;
    localparam int unsigned RCW     = $clog2(ROWS + 1);
    localparam int unsigned GW      = $clog2(GRAVITY_TICKS + 1);

    typedef enum logic [2:0] {
        S_SPAWN = 3'd0,
        S_WAIT  = 3'd1,
        S_CAL   = 3'd2,
        S_DROP  = 3'd3,
        S_PLACE = 3'd4,
        S_CLEAR = 3'd5,
        S_OVER  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     try_x_q, try_x_d, try_y_q, try_y_d, cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [1:0]          try_dir_q, try_dir_d, cur_dir_q, cur_dir_d;
    logic [CELL_W-1:0]   try_type_q, try_type_d, cur_type_q, cur_type_d;
    logic [BOARD_W-1:0]  board_q, board_d;
    logic [15:0]         lines_q, lines_d;
    logic                game_over_q, game_over_d;
    logic [GW-1:0]       grav_q, grav_d;
    logic                spawn_q, spawn_d, down_q, down_d, zero_q, zero_d;
    logic [RCW-1:0]      rd_q, rd_d, wr_q, wr_d, k_q, k_d;
    logic                row_full, grav_tick, clr_done;
    logic [RCW-1:0]      w_next;
    logic [16:0]         lines_sum;

    // A row is full when none of its cells is empty
    always_comb begin
        row_full = 1'b1;
        for (int unsigned c = 0; c < COLS; c++) begin
            row_full = row_full & (|board_q[(32'(rd_q) * COLS + c) * CELL_W +: CELL_W]);
        end
    end

    always_comb begin
        state_d     = state_q;
        try_x_d     = try_x_q;
        try_y_d     = try_y_q;
        try_dir_d   = try_dir_q;
        try_type_d  = try_type_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_dir_d   = cur_dir_q;
        cur_type_d  = cur_type_q;
        board_d     = board_q;
        lines_d     = lines_q;
        game_over_d = game_over_q;
        grav_d      = grav_q;
        spawn_d     = spawn_q;
        down_d      = down_q;
        zero_d      = zero_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        k_d         = k_q;
        grav_tick   = 1'b0;
        clr_done    = 1'b0;
        w_next      = wr_q;
        lines_sum   = 17'(lines_q) + 17'(k_q);

        case (state_q)
            S_SPAWN: begin
                try_x_d    = ID_W'(SPAWN_X);
                try_y_d    = ID_W'(SPAWN_Y);
                try_dir_d  = 2'd0;
                try_type_d = next_type;
                spawn_d    = 1'b1;
                down_d     = 1'b0;
                state_d    = S_CAL;
            end
            S_WAIT: begin
                grav_tick = (grav_q == GW'(GRAVITY_TICKS - 1));
                grav_d    = grav_tick ? '0 : grav_q + GW'(1);
                if (drop || mv_down || grav_tick || mv_left || mv_right || rot) begin
                    try_x_d    = cur_x_q;
                    try_y_d    = cur_y_q;
                    try_dir_d  = cur_dir_q;
                    try_type_d = cur_type_q;
                    down_d     = 1'b0;
                    state_d    = S_CAL;
                end
                // Single request per cycle, highest priority wins
                if (drop) begin
                    try_y_d = cur_y_q - ID_W'(1);
                    state_d = S_DROP;
                end else if (mv_down || grav_tick) begin
                    try_y_d = cur_y_q - ID_W'(1);
                    down_d  = 1'b1;
                end else if (mv_left) begin
                    try_x_d = cur_x_q - ID_W'(1);
                end else if (mv_right) begin
                    try_x_d = cur_x_q + ID_W'(1);
                end else if (rot) begin
                    try_dir_d = cur_dir_q + 2'd1;
                end
            end
            S_CAL: begin
                spawn_d = 1'b0;
                if (!is_collided) begin
                    cur_x_d    = try_x_q;
                    cur_y_d    = try_y_q;
                    cur_dir_d  = try_dir_q;
                    cur_type_d = try_type_q;
                    state_d    = S_WAIT;
                end else if (spawn_q) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else if (down_q) begin
                    state_d = S_PLACE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (is_collided) begin
                    state_d = S_PLACE;
                end else begin
                    cur_y_d = try_y_q;
                    try_y_d = try_y_q - ID_W'(1);
                end
            end
            S_PLACE: begin
                for (int unsigned j = 0; j < 4; j++) begin
                    if (32'(cur_ids[j*ID_W +: ID_W]) < CELLS) begin
                        board_d[32'(cur_ids[j*ID_W +: ID_W]) * CELL_W +: CELL_W] = cur_type_q;
                    end
                end
                grav_d  = '0;
                rd_d    = '0;
                wr_d    = '0;
                k_d     = '0;
                zero_d  = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                // Scan phase compacts non-full rows downward; zero phase blanks the vacated top rows
                if (!zero_q) begin
                    if (row_full) begin
                        k_d = k_q + RCW'(1);
                    end else begin
                        board_d[32'(wr_q) * ROW_W +: ROW_W] = board_q[32'(rd_q) * ROW_W +: ROW_W];
                    end
                    w_next = row_full ? wr_q : wr_q + RCW'(1);
                    wr_d   = w_next;
                    if (rd_q == RCW'(ROWS - 1)) begin
                        if (w_next == RCW'(ROWS)) begin
                            clr_done = 1'b1;
                        end else begin
                            zero_d = 1'b1;
                        end
                    end else begin
                        rd_d = rd_q + RCW'(1);
                    end
                end else begin
                    board_d[32'(wr_q) * ROW_W +: ROW_W] = '0;
                    wr_d = wr_q + RCW'(1);
                    if (wr_q == RCW'(ROWS - 1)) begin
                        clr_done = 1'b1;
                    end
                end
                if (clr_done) begin
                    lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                    zero_d  = 1'b0;
                    state_d = S_SPAWN;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_SPAWN;
            end
        endcase
    end

    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            state_q     <= S_SPAWN;
            try_x_q     <= ID_W'(SPAWN_X);
            try_y_q     <= ID_W'(SPAWN_Y);
            try_dir_q   <= 2'd0;
            try_type_q  <= CELL_W'(1);
            cur_x_q     <= ID_W'(SPAWN_X);
            cur_y_q     <= ID_W'(SPAWN_Y);
            cur_dir_q   <= 2'd0;
            cur_type_q  <= CELL_W'(1);
            board_q     <= '0;
            lines_q     <= '0;
            game_over_q <= 1'b0;
            grav_q      <= '0;
            spawn_q     <= 1'b0;
            down_q      <= 1'b0;
            zero_q      <= 1'b0;
            rd_q        <= '0;
            wr_q        <= '0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            try_x_q     <= try_x_d;
            try_y_q     <= try_y_d;
            try_dir_q   <= try_dir_d;
            try_type_q  <= try_type_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_dir_q   <= cur_dir_d;
            cur_type_q  <= cur_type_d;
            board_q     <= board_d;
            lines_q     <= lines_d;
            game_over_q <= game_over_d;
            grav_q      <= grav_d;
            spawn_q     <= spawn_d;
            down_q      <= down_d;
            zero_q      <= zero_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            k_q         <= k_d;
        end
    end

`ifdef TETRIS_SCORE_EN
    logic [19:0] score_q, score_d;
    logic [4:0]  pts;
    logic [20:0] score_sum;

    // Reward grows faster than the row count for multi-row clears
    always_comb begin
        case (k_q)
            RCW'(0): pts = 5'd0;
            RCW'(1): pts = 5'd1;
            RCW'(2): pts = 5'd3;
            RCW'(3): pts = 5'd5;
            default: pts = 5'd8;
        endcase
        score_sum = 21'(score_q) + 21'(pts);
        score_d   = score_q;
        if (clr_done) begin
            score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        end
    end

    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign try_x     = try_x_q;
    assign try_y     = try_y_q;
    assign try_dir   = try_dir_q;
    assign try_type  = try_type_q;
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;
    assign cur_dir   = cur_dir_q;
    assign cur_type  = cur_type_q;
    assign board     = board_q;
    assign state     = state_q;
    assign lines     = lines_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_tetris_engine.sv
// Directed bench for tetris_engine: reset, moves, gravity, hard drop, lock, multi-row clear, game over.
module tb_tetris_engine;

    localparam int unsigned COLS   = 10;
    localparam int unsigned ROWS   = 20;
    localparam int unsigned CELL_W = 3;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned GRAV   = 32;
    localparam int unsigned BW     = COLS * ROWS * CELL_W;

    logic                 main_clk = 1'b0;
    logic                 rst_1plus = 1'b1;
    logic                 mv_left = 1'b0, mv_right = 1'b0, mv_down = 1'b0, rot = 1'b0, drop = 1'b0;
    logic [CELL_W-1:0]    next_type = 3'd1;
    logic                 is_collided = 1'b0;
    logic [4*ID_W-1:0]    cur_ids = '0;
    logic [ID_W-1:0]      try_x, try_y, cur_x, cur_y;
    logic [1:0]           try_dir, cur_dir;
    logic [CELL_W-1:0]    try_type, cur_type;
    logic [BW-1:0]        board;
    logic [2:0]           state;
    logic [15:0]          lines;
    logic [19:0]          score;
    logic                 game_over;

    int n_tests = 0;
    int n_fail  = 0;
    logic [BW-1:0] exp_board;

    tetris_engine #(
        .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .ID_W(ID_W),
        .GRAVITY_TICKS(GRAV), .SPAWN_X(4), .SPAWN_Y(ROWS - 2)
    ) dut (
        .main_clk(main_clk), .rst_1plus(rst_1plus),
        .mv_left(mv_left), .mv_right(mv_right), .mv_down(mv_down), .rot(rot), .drop(drop),
        .next_type(next_type), .is_collided(is_collided), .cur_ids(cur_ids),
        .try_x(try_x), .try_y(try_y), .try_dir(try_dir), .try_type(try_type),
        .cur_x(cur_x), .cur_y(cur_y), .cur_dir(cur_dir), .cur_type(cur_type),
        .board(board), .state(state), .lines(lines), .score(score), .game_over(game_over)
    );

    always #5 main_clk = ~main_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic do_reset(input logic [CELL_W-1:0] nt);
        rst_1plus = 1'b1;
        {mv_left, mv_right, mv_down, rot, drop} = 5'b0;
        is_collided = 1'b0;
        next_type = nt;
        cur_ids = '0;
        tick();
        rst_1plus = 1'b0;
    endtask

    // Lock the current piece via a collided down move and count cycles spent in CLEAR
    task automatic place_piece(input logic [4*ID_W-1:0] ids, output int n);
        cur_ids = ids;
        mv_down = 1'b1;
        is_collided = 1'b1;
        tick();
        mv_down = 1'b0;
        tick();
        is_collided = 1'b0;
        tick();
        n = 0;
        while (state == 3'd5 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL clear_timeout: state %0d still CLEAR after %0d cycles", state, n);
        end
    endtask

    task automatic test_reset();
        rst_1plus = 1'b1;
        next_type = 3'd1;
        is_collided = 1'b0;
        tick();
        n_tests++;
        if ({state, lines, score, game_over} !== {3'd0, 16'd0, 20'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_regs: state %0d lines %0d score %0d go %0b, want 0 0 0 0", state, lines, score, game_over);
        end
        n_tests++;
        if (board !== '0) begin n_fail++; $display("FAIL reset_board: got nonzero, want 0"); end
        n_tests++;
        if ({cur_x, cur_y, cur_dir, cur_type, try_x, try_y, try_dir, try_type} !==
            {8'd4, 8'd18, 2'd0, 3'd1, 8'd4, 8'd18, 2'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL reset_pos: cur (%0d,%0d,%0d,%0d) try (%0d,%0d,%0d,%0d), want (4,18,0,1) both",
                     cur_x, cur_y, cur_dir, cur_type, try_x, try_y, try_dir, try_type);
        end
        rst_1plus = 1'b0;
        tick();
        n_tests++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL spawn_to_cal: state %0d, want 2", state); end
        tick();
        n_tests++;
        if ({state, cur_x, cur_y, cur_dir, cur_type} !== {3'd1, 8'd4, 8'd18, 2'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL spawn_commit: state %0d cur (%0d,%0d,%0d,%0d), want 1 (4,18,0,1)", state, cur_x, cur_y, cur_dir, cur_type);
        end
    endtask

    task automatic test_moves();
        do_reset(3'd3);
        tick(); tick();
        n_tests++;
        if (cur_type !== 3'd3) begin n_fail++; $display("FAIL spawn_type: got %0d, want 3", cur_type); end
        mv_left = 1'b1; tick(); mv_left = 1'b0;
        n_tests++;
        if ({state, try_x} !== {3'd2, 8'd3}) begin n_fail++; $display("FAIL left_try: state %0d try_x %0d, want 2 3", state, try_x); end
        tick();
        n_tests++;
        if ({state, cur_x} !== {3'd1, 8'd3}) begin n_fail++; $display("FAIL left_commit: state %0d cur_x %0d, want 1 3", state, cur_x); end
        mv_left = 1'b1; rot = 1'b1; tick(); mv_left = 1'b0; rot = 1'b0; tick();
        n_tests++;
        if ({cur_x, cur_dir} !== {8'd2, 2'd0}) begin n_fail++; $display("FAIL left_over_rot: cur_x %0d dir %0d, want 2 0", cur_x, cur_dir); end
        rot = 1'b1; tick(); rot = 1'b0; tick();
        n_tests++;
        if (cur_dir !== 2'd1) begin n_fail++; $display("FAIL rot: dir %0d, want 1", cur_dir); end
        mv_down = 1'b1; mv_left = 1'b1; tick(); mv_down = 1'b0; mv_left = 1'b0; tick();
        n_tests++;
        if ({cur_x, cur_y, state} !== {8'd2, 8'd17, 3'd1}) begin
            n_fail++; $display("FAIL down_over_left: x %0d y %0d state %0d, want 2 17 1", cur_x, cur_y, state);
        end
        mv_right = 1'b1; is_collided = 1'b1; tick(); mv_right = 1'b0; tick(); is_collided = 1'b0;
        n_tests++;
        if ({state, cur_x, board} !== {3'd1, 8'd2, BW'(0)}) begin
            n_fail++; $display("FAIL right_blocked: state %0d cur_x %0d board_nz %0b, want 1 2 0", state, cur_x, |board);
        end
    endtask

    task automatic test_gravity();
        do_reset(3'd1);
        tick(); tick();
        repeat (GRAV - 1) tick();
        n_tests++;
        if ({state, cur_y} !== {3'd1, 8'd18}) begin n_fail++; $display("FAIL grav_early: state %0d y %0d, want 1 18", state, cur_y); end
        tick();
        n_tests++;
        if ({state, try_y} !== {3'd2, 8'd17}) begin n_fail++; $display("FAIL grav_tick: state %0d try_y %0d, want 2 17", state, try_y); end
        tick();
        n_tests++;
        if ({state, cur_y} !== {3'd1, 8'd17}) begin n_fail++; $display("FAIL grav_commit: state %0d y %0d, want 1 17", state, cur_y); end
    endtask

    task automatic test_drop();
        int n;
        do_reset(3'd1);
        tick(); tick();
        cur_ids = {8'd145, 8'd156, 8'd155, 8'd154};
        drop = 1'b1; tick(); drop = 1'b0;
        n_tests++;
        if ({state, try_y} !== {3'd3, 8'd17}) begin n_fail++; $display("FAIL drop_enter: state %0d try_y %0d, want 3 17", state, try_y); end
        mv_left = 1'b1; tick(); mv_left = 1'b0;
        tick(); tick();
        n_tests++;
        if ({cur_x, cur_y} !== {8'd4, 8'd15}) begin n_fail++; $display("FAIL drop_fall: x %0d y %0d, want 4 15", cur_x, cur_y); end
        is_collided = 1'b1; tick(); is_collided = 1'b0;
        n_tests++;
        if ({state, cur_y} !== {3'd4, 8'd15}) begin n_fail++; $display("FAIL drop_lock: state %0d y %0d, want 4 15", state, cur_y); end
        tick();
        exp_board = '0;
        exp_board[154*CELL_W +: CELL_W] = 3'd1;
        exp_board[155*CELL_W +: CELL_W] = 3'd1;
        exp_board[156*CELL_W +: CELL_W] = 3'd1;
        exp_board[145*CELL_W +: CELL_W] = 3'd1;
        n_tests++;
        if ({state, board} !== {3'd5, exp_board}) begin n_fail++; $display("FAIL place_cells: state %0d board matches %0b, want 5 1", state, board === exp_board); end
        n = 0;
        while (state == 3'd5 && n < 100) begin tick(); n++; end
        n_tests++;
        if ({n, state, lines} !== {32'd20, 3'd0, 16'd0}) begin
            n_fail++; $display("FAIL clear_k0: cycles %0d state %0d lines %0d, want 20 0 0", n, state, lines);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        do_reset(3'd1);
        tick(); tick();
        cur_ids = {4{8'd5}};
        mv_down = 1'b1; is_collided = 1'b1; tick(); mv_down = 1'b0; tick(); is_collided = 1'b0; tick();
        repeat (5) tick();
        n_tests++;
        if ({state, board[5*CELL_W +: CELL_W]} !== {3'd5, 3'd1}) begin
            n_fail++; $display("FAIL mid_clear_pre: state %0d cell5 %0d, want 5 1", state, board[5*CELL_W +: CELL_W]);
        end
        #2 rst_1plus = 1'b1;
        #1;
        n_tests++;
        if ({state, board} !== {3'd0, BW'(0)}) begin n_fail++; $display("FAIL mid_clear_reset: state %0d board_nz %0b, want 0 0", state, |board); end
        tick();
        rst_1plus = 1'b0;
        n = 0;
    endtask

    task automatic test_multi_clear();
        int n;
        logic [4*ID_W-1:0] sets [5];
        sets[0] = {8'd3, 8'd2, 8'd1, 8'd0};
        sets[1] = {8'd7, 8'd6, 8'd5, 8'd4};
        sets[2] = {8'd12, 8'd11, 8'd10, 8'd8};
        sets[3] = {8'd16, 8'd15, 8'd14, 8'd13};
        sets[4] = {8'd18, 8'd18, 8'd18, 8'd17};
        do_reset(3'd5);
        tick(); tick();
        next_type = 3'd1;
        place_piece({4{8'd20}}, n);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            place_piece(sets[i], n);
            tick(); tick();
        end
        n_tests++;
        if (lines !== 16'd0) begin n_fail++; $display("FAIL preload_lines: got %0d, want 0", lines); end
        place_piece({8'd19, 8'd9, 8'd19, 8'd9}, n);
        exp_board = '0;
        exp_board[2:0] = 3'd5;
        n_tests++;
        if ({n, state} !== {32'd22, 3'd0}) begin n_fail++; $display("FAIL clear_k2_len: cycles %0d state %0d, want 22 0", n, state); end
        n_tests++;
        if (board !== exp_board) begin
            n_fail++; $display("FAIL clear_k2_board: cell0 %0d rows17_19_nz %0b, want 5 0", board[2:0], |board[BW-1:17*COLS*CELL_W]);
        end
        n_tests++;
        if (lines !== 16'd2) begin n_fail++; $display("FAIL clear_k2_lines: got %0d, want 2", lines); end
        n_tests++;
`ifdef TETRIS_SCORE_EN
        if (score !== 20'd3) begin n_fail++; $display("FAIL clear_k2_score: got %0d, want 3", score); end
`else
        if (score !== 20'd0) begin n_fail++; $display("FAIL clear_k2_score: got %0d, want 0", score); end
`endif
    endtask

    task automatic test_game_over();
        is_collided = 1'b1;
        tick();
        n_tests++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL over_cal: state %0d, want 2", state); end
        tick();
        n_tests++;
        if ({state, game_over} !== {3'd6, 1'b1}) begin n_fail++; $display("FAIL over_enter: state %0d go %0b, want 6 1", state, game_over); end
        is_collided = 1'b0;
        for (int i = 0; i < 100; i++) begin
            {mv_left, mv_right, mv_down, rot, drop} = 5'($urandom);
            is_collided = 1'($urandom);
            tick();
        end
        {mv_left, mv_right, mv_down, rot, drop} = 5'b0;
        is_collided = 1'b0;
        n_tests++;
        if ({state, game_over, cur_y, lines, board} !== {3'd6, 1'b1, 8'd18, 16'd2, exp_board}) begin
            n_fail++; $display("FAIL over_frozen: state %0d go %0b y %0d lines %0d board_ok %0b, want 6 1 18 2 1",
                               state, game_over, cur_y, lines, board === exp_board);
        end
        #2 rst_1plus = 1'b1;
        #1;
        n_tests++;
        if ({state, game_over, lines, board} !== {3'd0, 1'b0, 16'd0, BW'(0)}) begin
            n_fail++; $display("FAIL over_reset: state %0d go %0b lines %0d board_nz %0b, want 0 0 0 0", state, game_over, lines, |board);
        end
        tick();
        rst_1plus = 1'b0;
    endtask

    initial begin
        test_reset();
        test_moves();
        test_gravity();
        test_drop();
        test_reset_mid_clear();
        test_multi_clear();
        test_game_over();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
